// File: rtl/tdm_demux_1_4.sv
// tdm_demux_1_4: registered 1:4 TDM demultiplexer with frame-sync lock or explicit channel select
module tdm_demux_1_4 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clock_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Valid_In,
  input  logic                  Frame_Sync_In,
  input  logic                  Select_Mode_In,
  input  logic [1:0]            Select_In,
  output logic [DATA_WIDTH-1:0] Data_0_Out,
  output logic [DATA_WIDTH-1:0] Data_1_Out,
  output logic [DATA_WIDTH-1:0] Data_2_Out,
  output logic [DATA_WIDTH-1:0] Data_3_Out,
  output logic                  Valid_0_Out,
  output logic                  Valid_1_Out,
  output logic                  Valid_2_Out,
  output logic                  Valid_3_Out,
  output logic                  Frame_Done_Out,
  output logic                  Sync_Error_Out,
  output logic                  Locked_Out
);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t                r_state;
  logic [1:0]            r_cnt;
  logic                  r_mode_q;
  logic [DATA_WIDTH-1:0] r_data [4];
  logic [3:0]            r_valid;
  logic                  r_done;
  logic                  r_err;
  logic                  w_chg;
  state_t                w_st;
  state_t                w_nst;
  logic [1:0]            w_cnt;
  logic [1:0]            w_ch;
  logic [1:0]            w_ncnt;
  logic                  w_wr;
  logic                  w_done;
  logic                  w_err;
  // A mode change restarts the hunt before this cycle's sample is routed
  always_comb begin
    w_chg  = Enable_In && (Select_Mode_In != r_mode_q);
    w_st   = w_chg ? HUNT : r_state;
    w_cnt  = w_chg ? 2'd0 : r_cnt;
    w_wr   = Enable_In && Valid_In && (Select_Mode_In || Frame_Sync_In || w_st == LOCKED);
    w_ch   = Select_Mode_In ? Select_In : (Frame_Sync_In ? 2'd0 : w_cnt);
    w_nst  = Select_Mode_In ? HUNT : (w_wr ? LOCKED : w_st);
    w_ncnt = Select_Mode_In ? 2'd0 : (w_wr ? w_ch + 2'd1 : w_cnt);
    w_done = w_wr && !Select_Mode_In && !Frame_Sync_In && w_cnt == 2'd3;
    w_err  = w_wr && !Select_Mode_In && Frame_Sync_In && w_st == LOCKED && w_cnt != 2'd0;
  end
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      r_state  <= HUNT;
      r_cnt    <= '0;
      r_mode_q <= 1'b0;
      r_valid  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      for (int i = 0; i < 4; i++) r_data[i] <= '0;
    end else begin
      r_valid <= w_wr ? 4'b0001 << w_ch : 4'b0000;
      r_done  <= w_done;
      r_err   <= w_err;
      if (Enable_In) begin
        r_mode_q <= Select_Mode_In;
        r_state  <= w_nst;
        r_cnt    <= w_ncnt;
      end
      if (w_wr) r_data[w_ch] <= Data_In;
    end
  end
  assign Data_0_Out     = r_data[0];
  assign Data_1_Out     = r_data[1];
  assign Data_2_Out     = r_data[2];
  assign Data_3_Out     = r_data[3];
  assign Valid_0_Out    = r_valid[0];
  assign Valid_1_Out    = r_valid[1];
  assign Valid_2_Out    = r_valid[2];
  assign Valid_3_Out    = r_valid[3];
  assign Frame_Done_Out = r_done;
  assign Sync_Error_Out = r_err;
  assign Locked_Out     = (r_state == LOCKED);
endmodule

// File: tb/tb_tdm_demux_1_4.sv
// tb_tdm_demux_1_4: scoreboard bench; stimulus queues expected strobe events, a monitor pops them
module tb_tdm_demux_1_4;
  logic       clk = 1'b0;
  logic       rst, en, vin, sync, mode;
  logic [1:0] sel;
  logic [7:0] din;
  logic [7:0] d0, d1, d2, d3;
  logic       v0, v1, v2, v3, done, err, lock;
  int         checks = 0;
  int         failures = 0;
  typedef struct packed {
    logic [3:0]  v;
    logic [31:0] d;
    logic        done;
    logic        err;
    logic        lock;
  } ev_t;
  ev_t        exp_q [$];
  logic [7:0] e_d [4];
  tdm_demux_1_4 #(.DATA_WIDTH(8)) dut (
    .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Data_In(din), .Valid_In(vin),
    .Frame_Sync_In(sync), .Select_Mode_In(mode), .Select_In(sel),
    .Data_0_Out(d0), .Data_1_Out(d1), .Data_2_Out(d2), .Data_3_Out(d3),
    .Valid_0_Out(v0), .Valid_1_Out(v1), .Valid_2_Out(v2), .Valid_3_Out(v3),
    .Frame_Done_Out(done), .Sync_Error_Out(err), .Locked_Out(lock)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  always @(negedge clk) begin
    ev_t a, e;
    a = '{v: {v3, v2, v1, v0}, d: {d3, d2, d1, d0}, done: done, err: err, lock: lock};
    if (|a.v || a.done || a.err) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe actual=%h expected=none", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL event v=%b d=%h done=%b err=%b lock=%b expected v=%b d=%h done=%b err=%b lock=%b",
                   a.v, a.d, a.done, a.err, a.lock, e.v, e.d, e.done, e.err, e.lock);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic drive(input logic e, v, s, m, input logic [1:0] sl, input logic [7:0] d,
                       input int ch, input logic x_done, x_err, x_lock);
    en = e; vin = v; sync = s; mode = m; sel = sl; din = d;
    if (ch >= 0) begin
      e_d[ch] = d;
      exp_q.push_back('{v: 4'b0001 << ch, d: {e_d[3], e_d[2], e_d[1], e_d[0]},
                        done: x_done, err: x_err, lock: x_lock});
    end
    @(posedge clk);
    #1;
  endtask
  logic [7:0] xd [10] = '{8'h3C, 8'h5A, 8'h81, 8'hF0, 8'h07, 8'h99, 8'h42, 8'hEE, 8'h1B, 8'hC6};
  logic [1:0] xs [10] = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd1, 2'd2, 2'd0, 2'd3, 2'd3, 2'd0};
  logic       xf [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  initial begin
    for (int i = 0; i < 4; i++) e_d[i] = 8'h00;
    rst = 1'b1; en = 1'b0; vin = 1'b0; sync = 1'b0; mode = 1'b0; sel = 2'd0; din = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data", {d3, d2, d1, d0}, 32'h0);
    chk("reset_valid", {28'h0, v3, v2, v1, v0}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_err", {31'h0, err}, 32'h0);
    chk("reset_lock", {31'h0, lock}, 32'h0);
    rst = 1'b0;
    // hunt discards unsynced samples, then a full frame
    drive(1, 1, 0, 0, 0, 8'h11, -1, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 8'h22, -1, 0, 0, 0);
    chk("hunt_lock", {31'h0, lock}, 32'h0);
    drive(1, 1, 1, 0, 0, 8'hA0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 8'hA1, 1, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 8'hA2, 2, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 8'hA3, 3, 1, 0, 1);
    // resync mid-frame
    drive(1, 1, 1, 0, 0, 8'hC0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 8'hC1, 1, 0, 0, 1);
    drive(1, 1, 1, 0, 0, 8'h55, 0, 0, 1, 1);
    drive(1, 1, 0, 0, 0, 8'hC2, 1, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 8'hC3, 2, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 8'hC4, 3, 1, 0, 1);
    // gaps and enable stalls
    drive(1, 1, 1, 0, 0, 8'hB0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 8'hDD, -1, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 8'hB1, 1, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 8'hEE, -1, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 8'hEF, -1, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 8'hB2, 2, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 8'hB3, 3, 1, 0, 1);
    // reset in the middle of a frame
    drive(1, 1, 1, 0, 0, 8'hD0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 8'hD1, 1, 0, 0, 1);
    rst = 1'b1;
    drive(1, 1, 0, 0, 0, 8'hD2, -1, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) e_d[i] = 8'h00;
    chk("midrst_data", {d3, d2, d1, d0}, 32'h0);
    chk("midrst_lock", {31'h0, lock}, 32'h0);
    drive(1, 1, 0, 0, 0, 8'hD3, -1, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 8'hE0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 8'hE1, 1, 0, 0, 1);
    // explicit mode: Frame_Sync_In has no effect, FSM drops to HUNT
    for (int i = 0; i < 10; i++) drive(1, 1, xf[i], 1, xs[i], xd[i], int'(xs[i]), 0, 0, 0);
    chk("explicit_lock", {31'h0, lock}, 32'h0);
    // back to auto without sync: discard until next sync
    drive(1, 1, 0, 0, 0, 8'h77, -1, 0, 0, 0);
    chk("auto_switch_lock", {31'h0, lock}, 32'h0);
    drive(1, 1, 0, 0, 0, 8'h78, -1, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 8'h79, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 8'h7A, 1, 0, 0, 1);
    // a mode change while disabled is not sampled
    drive(0, 1, 0, 1, 2, 8'h13, -1, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 8'h7B, 2, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 8'h00, -1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'h0);
    chk("final_data", {d3, d2, d1, d0}, {e_d[3], e_d[2], e_d[1], e_d[0]});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tdm_demux_1_4.md
# tdm_demux_1_4

Registered 1:4 time-division demultiplexer: takes a single sample stream and writes each accepted sample to one of four channel output registers. Channel selection is either an internal round-robin counter, locked to a frame-sync marker, or an explicit select input. It is the receive-side partner of the team's 4:1 MUX / TDM serializer blocks. Each channel gets a one-cycle valid strobe and a held data register, and the block reports frame completion and sync errors.

## Interface

Parameters:
- DATA_WIDTH, 8, width of the sample and of each channel output

Ports:
- Clock_In  input  1  single clock; all state changes on its rising edge
- Reset_In  input  1  synchronous, active-high reset
- Enable_In  input  1  block enable; when 0 no sample is accepted and all state holds
- Data_In  input  DATA_WIDTH  input sample
- Valid_In  input  1  Data_In carries a sample this cycle
- Frame_Sync_In  input  1  qualifies the current sample as channel 0 of a frame; ignored unless Valid_In=1
- Select_Mode_In  input  1  0 = auto (round-robin counter), 1 = explicit (Select_In)
- Select_In  input  2  channel index used in explicit mode
- Data_0_Out .. Data_3_Out  output  DATA_WIDTH each  last sample written to channel n, held
- Valid_0_Out .. Valid_3_Out  output  1 each  one-cycle strobe: Data_n_Out updated this cycle
- Frame_Done_Out  output  1  one-cycle strobe: channel 3 written in auto mode while LOCKED
- Sync_Error_Out  output  1  one-cycle strobe: frame sync arrived with counter != 0 while LOCKED
- Locked_Out  output  1  1 when the auto-mode FSM is in LOCKED

## Operation

- Accept condition: Enable_In=1 and Valid_In=1. Nothing else writes channel registers.
- Internal state: FSM {HUNT, LOCKED}, 2-bit channel counter Chan_Cnt, registered copy of Select_Mode_In (Mode_Q).
- Reset behaviour:
  - FSM = HUNT, Chan_Cnt = 0.
  - All Data_n_Out, Valid_n_Out, Frame_Done_Out, Sync_Error_Out and Locked_Out = 0.
- Mode change: when Select_Mode_In != Mode_Q and Enable_In=1:
  - FSM goes to HUNT and Chan_Cnt to 0. The accept in that cycle is processed under the new mode.
  - Mode_Q updates.
- Explicit mode (Select_Mode_In=1):
  - Each accept writes Data_In to channel Select_In and strobes Valid_Select_In_Out.
  - FSM stays HUNT and Chan_Cnt stays 0.
  - Frame_Sync_In is ignored. Frame_Done_Out and Sync_Error_Out stay 0.
- Auto mode, HUNT:
  - Accepts with Frame_Sync_In=0 are discarded: no write, no strobe.
  - An accept with Frame_Sync_In=1 writes channel 0, sets Chan_Cnt=1, and moves the FSM to LOCKED.
- Auto mode, LOCKED, accept with Frame_Sync_In=0:
  - Writes channel Chan_Cnt; Chan_Cnt increments mod 4 (3 wraps to 0).
  - Writing channel 3 pulses Frame_Done_Out.
- Auto mode, LOCKED, accept with Frame_Sync_In=1:
  - Chan_Cnt=0: normal channel 0 write, Chan_Cnt=1.
  - Chan_Cnt!=0: resync. Writes channel 0, sets Chan_Cnt=1, pulses Sync_Error_Out, stays LOCKED, and does not pulse Frame_Done_Out.
- Locked_Out = (FSM == LOCKED), registered.
- Enable_In=0: every register holds, all strobes are 0, and mode changes are not sampled.
- Reset_In has priority over every other input, including in the middle of a frame. The partial frame is discarded and no strobes are emitted in the reset cycle.

## Timing

- Latency is one cycle. An accept at edge k makes Data_n_Out and Valid_n_Out visible after edge k; Valid_n_Out is high for exactly that one cycle.
- At most one Valid_n_Out is high in any cycle.
- Frame_Done_Out and Sync_Error_Out are coincident with the Valid_n_Out of the triggering write.
- Throughput is one sample per cycle sustained. Gaps (Valid_In=0) are allowed anywhere and do not advance Chan_Cnt.
- Data_n_Out changes only on a write to channel n.
- All outputs are registered; there is no combinational path from input to output.

## Test plan

- Reset with Reset_In=1 for 2 cycles -> all outputs 0, Locked_Out=0. Then assert Reset_In mid-frame after 2 accepted samples -> all outputs 0 and Chan_Cnt restarts in HUNT.
- Auto mode, DATA_WIDTH=8. Drive samples 0x11 and 0x22 without sync (both discarded, no strobes), then 0xA0 with sync, then 0xA1, 0xA2, 0xA3 back-to-back -> Valid_0..3 strobe on consecutive cycles; Data_0..3_Out = A0/A1/A2/A3; Frame_Done_Out pulses with Valid_3; Locked_Out=1 from the cycle after 0xA0.
- LOCKED, after writes to channels 0 and 1, send 0x55 with Frame_Sync_In=1 -> Data_0_Out=0x55, Sync_Error_Out pulses once, no Frame_Done_Out. The next sample goes to channel 1.
- Frame with Valid_In=0 gaps and Enable_In=0 stalls interleaved (e.g. B0, gap, B1, stall with Valid_In=1, B2, B3) -> same channel mapping as the gap-free case; no strobe during gaps or stalls; the stalled sample is not accepted.
- Explicit mode with 10 random Data_In/Select_In pairs -> each sample lands on channel Select_In one cycle later, other channels hold. Frame_Sync_In toggled randomly has no effect; Frame_Done_Out=0 throughout.
- Switch mode from explicit to auto while Frame_Sync_In=0 -> Locked_Out=0 and samples are discarded until the next sync.
